// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide unit owning HI and LO.
//   MULT: radix-2 Booth, one step per cycle over ITER cycles.
//   DIV : restoring division on magnitudes, sign fix-up at the end.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   mult_start, div_start operation requests, sampled only while idle
//   A, B                  rs / rt operands, latched on the start edge
//   HI_output, LO_output  MULT: product high/low; DIV: remainder/quotient
//   busy                  high while an operation (or its done cycle) is in flight
//   done                  one-cycle completion pulse
//   div_zero              one-cycle pulse with done when DIV had B == 0
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI_output,
    output logic [WIDTH-1:0] LO_output,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(ITER) + 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;    // Booth accumulator / division partial remainder
    logic [WIDTH-1:0] q;      // multiplier / dividend shifting out, quotient shifting in
    logic             qm1;    // Booth Q-1 bit
    logic [WIDTH-1:0] m;      // multiplicand / divisor magnitude
    logic             neg_q;  // quotient sign
    logic             neg_r;  // remainder sign (dividend sign)

    logic [WIDTH-1:0] a_abs, b_abs;
    assign a_abs = A[WIDTH-1] ? -A : A;
    assign b_abs = B[WIDTH-1] ? -B : B;

    // Booth step. The add runs one bit wider so the bit shifted into the
    // accumulator top is the true sign even when m is the most negative value.
    logic [WIDTH:0]   bsum;
    logic [WIDTH-1:0] mul_acc_n, mul_q_n;
    always_comb begin
        bsum = {acc[WIDTH-1], acc};
        case ({q[0], qm1})
            2'b01:   bsum = {acc[WIDTH-1], acc} + {m[WIDTH-1], m};
            2'b10:   bsum = {acc[WIDTH-1], acc} - {m[WIDTH-1], m};
            default: bsum = {acc[WIDTH-1], acc};
        endcase
    end
    assign mul_acc_n = bsum[WIDTH:1];
    assign mul_q_n   = {bsum[0], q[WIDTH-1:1]};

    // Restoring step: shifted remainder is at most 2*(m-1)+1, so it fits in
    // WIDTH+1 bits and the trial's top bit is the borrow.
    logic [WIDTH:0]   rsh, trial;
    logic             ge;
    logic [WIDTH-1:0] div_r_n, div_q_n;
    assign rsh     = {acc, q[WIDTH-1]};
    assign trial   = rsh - {1'b0, m};
    assign ge      = ~trial[WIDTH];
    assign div_r_n = ge ? trial[WIDTH-1:0] : rsh[WIDTH-1:0];
    assign div_q_n = {q[WIDTH-2:0], ge};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            q         <= '0;
            qm1       <= 1'b0;
            m         <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            HI_output <= '0;
            LO_output <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (mult_start) begin
                        m     <= A;
                        q     <= B;
                        acc   <= '0;
                        qm1   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MULT;
                    end else if (div_start) begin
                        busy <= 1'b1;
                        if (B == '0) begin
                            // HI/LO are left untouched on divide-by-zero
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            m     <= b_abs;
                            q     <= a_abs;
                            acc   <= '0;
                            neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            neg_r <= A[WIDTH-1];
                            cnt   <= '0;
                            state <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc <= mul_acc_n;
                    q   <= mul_q_n;
                    qm1 <= q[0];
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        HI_output <= mul_acc_n;
                        LO_output <= mul_q_n;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DIV: begin
                    acc <= div_r_n;
                    q   <= div_q_n;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // most-negative / -1 wraps back to most-negative
                        LO_output <= neg_q ? -div_q_n : div_q_n;
                        HI_output <= neg_r ? -div_r_n : div_r_n;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random operations, checked
// against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start, div_start;
    logic [31:0] A, B;
    logic [31:0] HI_output, LO_output;
    logic        busy, done, div_zero;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .reset(reset),
        .mult_start(mult_start), .div_start(div_start),
        .A(A), .B(B),
        .HI_output(HI_output), .LO_output(LO_output),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: full-width signed arithmetic. SV division truncates toward
    // zero and % takes the dividend's sign, matching MIPS DIV.
    task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (b != 0) begin
            p = sa / sb;
            exp_lo = p[31:0];
            p = sa % sb;
            exp_hi = p[31:0];
        end
    endtask

    // Called at the negedge right after the start edge; counts posedges until done.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, input bit both);
        int cyc;
        bit dz;
        bit md;
        md = is_div && !both;
        dz = md && (b == 0);
        @(negedge clk);
        A = a; B = b;
        mult_start = !is_div || both;
        div_start  = is_div || both;
        @(negedge clk);
        mult_start = 0; div_start = 0;
        A = $urandom; B = $urandom;
        check({tag, " busy_start"}, busy, 1);
        check({tag, " hi_hold"}, HI_output, exp_hi);
        model(md, a, b);
        wait_done(cyc);
        check({tag, " latency"}, cyc, dz ? 0 : 32);
        check({tag, " hi"}, HI_output, exp_hi);
        check({tag, " lo"}, LO_output, exp_lo);
        check({tag, " div_zero"}, div_zero, dz);
        check({tag, " busy_done"}, busy, 1);
        @(negedge clk);
        check({tag, " done_clear"}, {done, busy, div_zero}, 0);
    endtask

    initial begin
        int cyc;
        bit seen;
        logic [31:0] ra, rb;
        reset = 1; mult_start = 0; div_start = 0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", {HI_output, LO_output}, 0);
        check("reset flags", {busy, done, div_zero}, 0);
        reset = 0;

        run_op("mult 7*-3", 0, 32'd7, 32'hFFFF_FFFD, 0);

        // Reset 10 cycles into a multiply aborts it immediately
        @(negedge clk);
        A = 32'h0123_4567; B = 32'h0000_0089; mult_start = 1;
        @(negedge clk);
        mult_start = 0;
        repeat (9) @(negedge clk);
        reset = 1;
        #1;
        check("abort hilo", {HI_output, LO_output}, 0);
        check("abort busy", busy, 0);
        @(negedge clk);
        reset = 0;
        exp_hi = '0; exp_lo = '0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort no done", seen, 0);

        run_op("mult min*min both", 0, 32'h8000_0000, 32'h8000_0000, 1);
        run_op("div -7/2", 1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div 100/7", 1, 32'd100, 32'd7, 0);
        run_op("div setup", 1, 32'h0ACF_1234, 32'h0000_2000, 0);
        check("setup hi", HI_output, 32'h1234);
        check("setup lo", LO_output, 32'h5678);
        run_op("div by zero", 1, 32'hDEAD_BEEF, 32'd0, 0);

        // Start held high through busy: second op begins only after IDLE
        @(negedge clk);
        A = 32'd7; B = 32'd9; mult_start = 1;
        @(negedge clk);
        A = 32'hFFFF_FFF0; B = 32'h0000_0011;
        model(0, 32'd7, 32'd9);
        wait_done(cyc);
        check("b2b first latency", cyc, 32);
        check("b2b first result", {HI_output, LO_output}, {exp_hi, exp_lo});
        @(negedge clk);
        check("b2b idle gap", {busy, done}, 0);
        @(negedge clk);
        check("b2b second start", busy, 1);
        mult_start = 0; A = $urandom; B = $urandom;
        model(0, 32'hFFFF_FFF0, 32'h0000_0011);
        wait_done(cyc);
        check("b2b second latency", cyc, 32);
        check("b2b second result", {HI_output, LO_output}, {exp_hi, exp_lo});
        @(negedge clk);

        run_op("div min/-1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), bit'($urandom_range(0, 1)), ra, rb, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
